max7219_cascade_if: RTL and testbench

- Parametrised successor to the single-device MAX7219 serial interface; drives a daisy chain of G_NB_DEVICES MAX7219 drivers from one shared DIN/CLK/LOAD bus.
- Serialises one 16-bit word per device, MSB first, farthest device first, in a single frame, then issues one LOAD pulse.
- Per-device enable mask replaces disabled devices' words with NO-OP (16'h0000), so one device can be updated without disturbing the others.
- Sits between display-control logic (matrix/7-seg controllers) and the board pins.

---
 rtl/max7219_cascade_if.sv | 257 +++++++++++++++++++++++++
 tb/tb_max7219_cascade_if.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/max7219_cascade_if.sv
// max7219_cascade_if
//   Drives a daisy chain of G_NB_DEVICES MAX7219 drivers from one DIN/CLK/LOAD bus.
//   A request serialises one 16-bit word per device. The farthest device's word is sent first,
//   each word MSB first. An optional LOAD pulse follows the frame.
//   Devices whose i_dev_en bit is 0 receive a NO-OP word (16'h0000), so their state is untouched.
//
// Parameters:
//   G_NB_DEVICES      number of cascaded devices (1..16)
//   G_MAX_HALF_PERIOD o_max7219_clk half period in clk cycles (>=1)
//   G_LOAD_DURATION   o_max7219_load high time in clk cycles (>=1)
//
// Ports:
//   clk, rst_n      system clock, synchronous active-low reset
//   i_start         request pulse, accepted when not busy
//   i_en_load       sampled with i_start; 1 issues LOAD after the frame
//   i_data          word for device d at [16d+15:16d]; device 0 is nearest the FPGA
//   i_dev_en        sampled with i_start; bit d = 0 sends NO-OP to device d
//   o_max7219_load  LOAD/CS pin
//   o_max7219_data  DIN pin
//   o_max7219_clk   serial clock pin
//   o_busy          high from acceptance through the o_done cycle
//   o_done          one-cycle pulse at the end of a request
//
// Build option:
//   MAX7219_CASCADE_PENDING_REQ_EN  adds a one-entry request buffer. A start while busy is held
//                                   (last wins) and is launched straight from the DONE cycle.
//                                   Without it, starts while busy are dropped.

module max7219_cascade_if #(
  parameter int unsigned G_NB_DEVICES      = 4,
  parameter int unsigned G_MAX_HALF_PERIOD = 4,
  parameter int unsigned G_LOAD_DURATION   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_start,
  input  logic                         i_en_load,
  input  logic [16*G_NB_DEVICES-1:0]   i_data,
  input  logic [G_NB_DEVICES-1:0]      i_dev_en,
  output logic                         o_max7219_load,
  output logic                         o_max7219_data,
  output logic                         o_max7219_clk,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int unsigned FrameW = 16 * G_NB_DEVICES;
  localparam int unsigned BitW   = $clog2(FrameW + 1);
  localparam int unsigned HalfW  = $clog2(G_MAX_HALF_PERIOD + 1);
  localparam int unsigned LoadW  = $clog2(G_LOAD_DURATION + 1);

  typedef enum logic [1:0] {StIdle, StShift, StLoad, StDone} state_e;

  state_e            state_q, state_d;
  logic [HalfW-1:0]  hcnt_q, hcnt_d;
  logic [BitW-1:0]   bcnt_q, bcnt_d;
  logic [LoadW-1:0]  lcnt_q, lcnt_d;
  logic [FrameW-1:0] shreg_q, shreg_d;
  logic              en_load_q, en_load_d;
  logic              load_q, load_d;
  logic              data_q, data_d;
  logic              sclk_q, sclk_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              launch;
  logic [FrameW-1:0] launch_frame;
  logic              launch_en_load;

  // Frame bit layout equals i_data layout: word N-1 sits at the top and is shifted out first.
  function automatic logic [FrameW-1:0] build_frame(input logic [FrameW-1:0]       data,
                                                    input logic [G_NB_DEVICES-1:0] en);
    logic [FrameW-1:0] frame;
    frame = '0;
    for (int d = 0; d < int'(G_NB_DEVICES); d++) begin
      frame[16*d +: 16] = en[d] ? data[16*d +: 16] : 16'h0000;
    end
    return frame;
  endfunction

`ifdef MAX7219_CASCADE_PENDING_REQ_EN
  logic                    pend_valid_q, pend_valid_d;
  logic [FrameW-1:0]       pend_data_q, pend_data_d;
  logic [G_NB_DEVICES-1:0] pend_dev_en_q, pend_dev_en_d;
  logic                    pend_en_load_q, pend_en_load_d;

  always_comb begin
    pend_valid_d   = pend_valid_q;
    pend_data_d    = pend_data_q;
    pend_dev_en_d  = pend_dev_en_q;
    pend_en_load_d = pend_en_load_q;
    if (busy_q && i_start) begin
      pend_valid_d   = 1'b1;
      pend_data_d    = i_data;
      pend_dev_en_d  = i_dev_en;
      pend_en_load_d = i_en_load;
    end
    // DONE either launches whatever is pending (buffer or a same-cycle start) or has nothing.
    if (state_q == StDone) begin
      pend_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_valid_q   <= 1'b0;
      pend_data_q    <= '0;
      pend_dev_en_q  <= '0;
      pend_en_load_q <= 1'b0;
    end else begin
      pend_valid_q   <= pend_valid_d;
      pend_data_q    <= pend_data_d;
      pend_dev_en_q  <= pend_dev_en_d;
      pend_en_load_q <= pend_en_load_d;
    end
  end
`endif

  always_comb begin
    state_d        = state_q;
    hcnt_d         = hcnt_q;
    bcnt_d         = bcnt_q;
    lcnt_d         = lcnt_q;
    shreg_d        = shreg_q;
    en_load_d      = en_load_q;
    load_d         = load_q;
    data_d         = data_q;
    sclk_d         = sclk_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    launch         = 1'b0;
    launch_frame   = '0;
    launch_en_load = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          launch         = 1'b1;
          launch_frame   = build_frame(i_data, i_dev_en);
          launch_en_load = i_en_load;
        end
      end

      StShift: begin
        if (hcnt_q == HalfW'(G_MAX_HALF_PERIOD - 1)) begin
          hcnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // End of a bit slot.
            sclk_d = 1'b0;
            if (bcnt_q == BitW'(FrameW - 1)) begin
              data_d  = 1'b0;
              shreg_d = '0;
              if (en_load_q) begin
                state_d = StLoad;
                load_d  = 1'b1;
                lcnt_d  = '0;
              end else begin
                state_d = StDone;
                done_d  = 1'b1;
              end
            end else begin
              bcnt_d  = bcnt_q + BitW'(1);
              shreg_d = {shreg_q[FrameW-2:0], 1'b0};
              data_d  = shreg_q[FrameW-2];
            end
          end
        end else begin
          hcnt_d = hcnt_q + HalfW'(1);
        end
      end

      StLoad: begin
        if (lcnt_q == LoadW'(G_LOAD_DURATION - 1)) begin
          load_d  = 1'b0;
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          lcnt_d = lcnt_q + LoadW'(1);
        end
      end

      StDone: begin
`ifdef MAX7219_CASCADE_PENDING_REQ_EN
        // A start in this very cycle is newer than the buffer, so it wins.
        if (i_start) begin
          launch         = 1'b1;
          launch_frame   = build_frame(i_data, i_dev_en);
          launch_en_load = i_en_load;
        end else if (pend_valid_q) begin
          launch         = 1'b1;
          launch_frame   = build_frame(pend_data_q, pend_dev_en_q);
          launch_en_load = pend_en_load_q;
        end else begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
`else
        state_d = StIdle;
        busy_d  = 1'b0;
`endif
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // First bit slot begins the cycle after launch, clock low, MSB of the frame on DIN.
    if (launch) begin
      state_d   = StShift;
      hcnt_d    = '0;
      bcnt_d    = '0;
      shreg_d   = launch_frame;
      data_d    = launch_frame[FrameW-1];
      sclk_d    = 1'b0;
      en_load_d = launch_en_load;
      busy_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      hcnt_q    <= '0;
      bcnt_q    <= '0;
      lcnt_q    <= '0;
      shreg_q   <= '0;
      en_load_q <= 1'b0;
      load_q    <= 1'b0;
      data_q    <= 1'b0;
      sclk_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      bcnt_q    <= bcnt_d;
      lcnt_q    <= lcnt_d;
      shreg_q   <= shreg_d;
      en_load_q <= en_load_d;
      load_q    <= load_d;
      data_q    <= data_d;
      sclk_q    <= sclk_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_max7219_load = load_q;
  assign o_max7219_data = data_q;
  assign o_max7219_clk  = sclk_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;

endmodule

// File: tb/tb_max7219_cascade_if.sv
// Bench for max7219_cascade_if with N=4, H=4, L=4.
// A frame is W=64 bits, 8 cycles per bit, so the frame ends at cycle 512.

module tb_max7219_cascade_if;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic        i_en_load;
  logic [63:0] i_data;
  logic [3:0]  i_dev_en;
  logic        o_max7219_load;
  logic        o_max7219_data;
  logic        o_max7219_clk;
  logic        o_busy;
  logic        o_done;

  max7219_cascade_if #(
    .G_NB_DEVICES      (4),
    .G_MAX_HALF_PERIOD (4),
    .G_LOAD_DURATION   (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_start        (i_start),
    .i_en_load      (i_en_load),
    .i_data         (i_data),
    .i_dev_en       (i_dev_en),
    .o_max7219_load (o_max7219_load),
    .o_max7219_data (o_max7219_data),
    .o_max7219_clk  (o_max7219_clk),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  dev_en;
    logic        en_load;
    logic [63:0] frame;
    int          load_at;
    int          load_len;
    int          done_at;
  } vec_t;

  vec_t vecs[5];

  int checks;
  int fails;

  // Values gathered by monitor()
  logic [63:0] m_bits;
  int          m_rises;
  int          m_first_rise;
  int          m_unstable;
  int          m_load_at;
  int          m_load_len;
  int          m_done_at;
  int          m_busy_gap;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Presents a request in the current cycle (cycle 0).
  task automatic start_req(input logic [63:0] data, input logic [3:0] dev_en, input logic en_ld);
    @(negedge clk);
    i_start   = 1'b1;
    i_data    = data;
    i_dev_en  = dev_en;
    i_en_load = en_ld;
  endtask

  // Observes cycles 1.. until o_done. Optionally pulses a second start at cycle pulse_at or
  // pulls reset low at cycle abort_at and returns.
  task automatic monitor(input int pulse_at, input int abort_at);
    logic prev_clk;
    logic cur_bit;
    prev_clk     = 1'b0;
    cur_bit      = 1'b0;
    m_bits       = '0;
    m_rises      = 0;
    m_first_rise = 0;
    m_unstable   = 0;
    m_load_at    = 0;
    m_load_len   = 0;
    m_done_at    = 0;
    m_busy_gap   = 0;
    for (int c = 1; c <= 1500; c++) begin
      @(negedge clk);
      if (c == 1) begin
        // Scramble inputs after acceptance: they must not be sampled again.
        i_start   = 1'b0;
        i_data    = {$urandom, $urandom};
        i_dev_en  = 4'($urandom);
        i_en_load = 1'($urandom);
      end
      if (c == pulse_at) begin
        i_start   = 1'b1;
        i_data    = 64'h8001_FFFF_5555_1234;
        i_dev_en  = 4'b1101;
        i_en_load = 1'b0;
      end
      if (pulse_at != 0 && c == pulse_at + 1) i_start = 1'b0;
      if (c == abort_at) begin
        rst_n = 1'b0;
        return;
      end
      if (o_max7219_clk && !prev_clk) begin
        m_bits  = {m_bits[62:0], o_max7219_data};
        cur_bit = o_max7219_data;
        m_rises++;
        if (m_first_rise == 0) m_first_rise = c;
      end
      if (o_max7219_clk && (o_max7219_data != cur_bit)) m_unstable++;
      prev_clk = o_max7219_clk;
      if (o_max7219_load) begin
        if (m_load_at == 0) m_load_at = c;
        m_load_len++;
      end
      if (!o_busy) m_busy_gap++;
      if (o_done) begin
        m_done_at = c;
        break;
      end
    end
  endtask

  task automatic check_core(input string tag, input logic [63:0] frame, input int load_at,
                            input int load_len, input int done_at);
    chk({tag, "_frame"}, m_bits, frame);
    chk({tag, "_rises"}, 64'(m_rises), 64'd64);
    chk({tag, "_first_rise"}, 64'(m_first_rise), 64'd5);
    chk({tag, "_data_stable"}, 64'(m_unstable), 64'd0);
    chk({tag, "_load_at"}, 64'(m_load_at), 64'(load_at));
    chk({tag, "_load_len"}, 64'(m_load_len), 64'(load_len));
    chk({tag, "_done_at"}, 64'(m_done_at), 64'(done_at));
    chk({tag, "_busy_held"}, 64'(m_busy_gap), 64'd0);
  endtask

  task automatic check_idle_next(input string tag);
    @(negedge clk);
    chk({tag, "_idle_after"},
        {59'd0, o_max7219_load, o_max7219_data, o_max7219_clk, o_busy, o_done}, 64'd0);
  endtask

  int zero_bad;
  int activity;

  initial begin
    checks    = 0;
    fails     = 0;
    rst_n     = 1'b0;
    i_start   = 1'b1;   // a start during reset must not do anything
    i_en_load = 1'b1;
    i_data    = 64'hFFFF_FFFF_FFFF_FFFF;
    i_dev_en  = 4'hF;

    vecs[0] = '{64'h0A0F_0B07_0C01_0F00, 4'hF,    1'b1, 64'h0A0F_0B07_0C01_0F00, 513, 4, 517};
    vecs[1] = '{64'h0A0F_0B07_0C01_0F00, 4'b0010, 1'b1, 64'h0000_0000_0C01_0000, 513, 4, 517};
    vecs[2] = '{64'h0A0F_0B07_0C01_0F00, 4'hF,    1'b0, 64'h0A0F_0B07_0C01_0F00, 0,   0, 513};
    vecs[3] = '{64'h1234_5678_9ABC_DEF0, 4'b1001, 1'b1, 64'h1234_0000_0000_DEF0, 513, 4, 517};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 4'h0,    1'b1, 64'h0000_0000_0000_0000, 513, 4, 517};

    // Reset, with i_start held high
    zero_bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if ({o_max7219_load, o_max7219_data, o_max7219_clk, o_busy, o_done} != 5'd0) zero_bad++;
    end
    chk("reset_outputs_zero", 64'(zero_bad), 64'd0);
    i_start = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    chk("post_reset_idle",
        {59'd0, o_max7219_load, o_max7219_data, o_max7219_clk, o_busy, o_done}, 64'd0);

    // Table-driven frames
    for (int v = 0; v < 5; v++) begin
      start_req(vecs[v].data, vecs[v].dev_en, vecs[v].en_load);
      monitor(0, 0);
      check_core($sformatf("vec%0d", v), vecs[v].frame, vecs[v].load_at, vecs[v].load_len,
                 vecs[v].done_at);
      check_idle_next($sformatf("vec%0d", v));
    end

    // Start while busy, at cycle 100
    start_req(vecs[0].data, vecs[0].dev_en, vecs[0].en_load);
    monitor(100, 0);
    check_core("busy1", vecs[0].frame, 513, 4, 517);
`ifdef MAX7219_CASCADE_PENDING_REQ_EN
    // Second frame: 8001, FFFF, NO-OP, 1234 and no LOAD, first slot right after o_done
    monitor(0, 0);
    check_core("busy2", 64'h8001_FFFF_0000_1234, 0, 0, 513);
    check_idle_next("busy2");
`else
    activity = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ({o_max7219_load, o_max7219_data, o_max7219_clk, o_busy, o_done} != 5'd0) activity++;
    end
    chk("busy_start_dropped", 64'(activity), 64'd0);
`endif

    // Reset at cycle 200 of a frame
    start_req(vecs[0].data, vecs[0].dev_en, vecs[0].en_load);
    monitor(0, 200);
    @(negedge clk);
    chk("abort_outputs_zero",
        {59'd0, o_max7219_load, o_max7219_data, o_max7219_clk, o_busy, o_done}, 64'd0);
    activity = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (o_done || o_busy) activity++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_done || o_busy || o_max7219_clk || o_max7219_load) activity++;
    end
    chk("abort_no_done", 64'(activity), 64'd0);
    start_req(vecs[0].data, vecs[0].dev_en, vecs[0].en_load);
    monitor(0, 0);
    check_core("after_abort", vecs[0].frame, 513, 4, 517);
    check_idle_next("after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
